// File: rtl/control_sequencer.sv
// Microcode control sequencer: steps a T-state counter through fetch/execute
// and decodes opcode plus ALU flags into register load strobes and bus enables.
module control_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       flag_c,
    input  logic       flag_z,
    output logic       co,
    output logic       ro,
    output logic       io,
    output logic       ao,
    output logic       eo,
    output logic       mi,
    output logic       ri,
    output logic       ii,
    output logic       ai,
    output logic       bi,
    output logic       oi,
    output logic       ce,
    output logic       j,
    output logic       su,
    output logic       fi,
    output logic       hlt,
    output logic [2:0] step
);

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [2:0] r_step;
    logic       r_halted;
    logic       w_last;
    logic [2:0] w_next_step;

    // Last micro-step of the current instruction; fetch steps are never last.
    always_comb begin
        w_last = 1'b0;
        case (r_step)
            S2:      w_last = !((opcode == OP_LDA) || (opcode == OP_ADD) ||
                                (opcode == OP_SUB) || (opcode == OP_STA));
            S3:      w_last = (opcode == OP_LDA) || (opcode == OP_STA);
            S4:      w_last = 1'b1;
            default: w_last = 1'b0;
        endcase
    end

    always_comb begin
        w_next_step = r_step + 3'd1;
        if (w_last || (r_step >= S4)) begin
            w_next_step = S0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step   <= S0;
            r_halted <= 1'b0;
        end else if (r_halted) begin
            r_step   <= r_step;
            r_halted <= 1'b1;
        end else if ((r_step == S2) && (opcode == OP_HLT)) begin
            // Step freezes at 2 so the debug view shows where the halt happened.
            r_halted <= 1'b1;
        end else begin
            r_step <= w_next_step;
        end
    end

    always_comb begin
        co  = 1'b0;
        ro  = 1'b0;
        io  = 1'b0;
        ao  = 1'b0;
        eo  = 1'b0;
        mi  = 1'b0;
        ri  = 1'b0;
        ii  = 1'b0;
        ai  = 1'b0;
        bi  = 1'b0;
        oi  = 1'b0;
        ce  = 1'b0;
        j   = 1'b0;
        su  = 1'b0;
        fi  = 1'b0;
        hlt = 1'b0;
        if (rst) begin
            hlt = 1'b0;
        end else if (r_halted) begin
            hlt = 1'b1;
        end else begin
            case (r_step)
                S0: begin
                    co = 1'b1;
                    mi = 1'b1;
                end
                S1: begin
                    ro = 1'b1;
                    ii = 1'b1;
                    ce = 1'b1;
                end
                S2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            io = 1'b1;
                            mi = 1'b1;
                        end
                        OP_LDI: begin
                            io = 1'b1;
                            ai = 1'b1;
                        end
                        OP_JMP: begin
                            io = 1'b1;
                            j  = 1'b1;
                        end
                        OP_JC: begin
                            io = flag_c;
                            j  = flag_c;
                        end
                        OP_JZ: begin
                            io = flag_z;
                            j  = flag_z;
                        end
                        OP_OUT: begin
                            ao = 1'b1;
                            oi = 1'b1;
                        end
                        OP_HLT:  hlt = 1'b1;
                        OP_NOP:  hlt = 1'b0;
                        default: hlt = 1'b0;
                    endcase
                end
                S3: begin
                    case (opcode)
                        OP_LDA: begin
                            ro = 1'b1;
                            ai = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ro = 1'b1;
                            bi = 1'b1;
                        end
                        OP_STA: begin
                            ao = 1'b1;
                            ri = 1'b1;
                        end
                        default: hlt = 1'b0;
                    endcase
                end
                S4: begin
                    if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        eo = 1'b1;
                        ai = 1'b1;
                        fi = 1'b1;
                        su = (opcode == OP_SUB);
                    end
                end
                default: hlt = 1'b0;
            endcase
        end
    end

    assign step = r_step;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: hand-computed control words per
// micro-step, halt/reset behaviour, and a randomized bus-exclusivity sweep.
module tb_control_sequencer;

    localparam logic [15:0] C_CO  = 16'h8000;
    localparam logic [15:0] C_RO  = 16'h4000;
    localparam logic [15:0] C_IO  = 16'h2000;
    localparam logic [15:0] C_AO  = 16'h1000;
    localparam logic [15:0] C_EO  = 16'h0800;
    localparam logic [15:0] C_MI  = 16'h0400;
    localparam logic [15:0] C_RI  = 16'h0200;
    localparam logic [15:0] C_II  = 16'h0100;
    localparam logic [15:0] C_AI  = 16'h0080;
    localparam logic [15:0] C_BI  = 16'h0040;
    localparam logic [15:0] C_OI  = 16'h0020;
    localparam logic [15:0] C_CE  = 16'h0010;
    localparam logic [15:0] C_J   = 16'h0008;
    localparam logic [15:0] C_SU  = 16'h0004;
    localparam logic [15:0] C_FI  = 16'h0002;
    localparam logic [15:0] C_HLT = 16'h0001;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic       flag_c;
    logic       flag_z;
    logic       co, ro, io, ao, eo, mi, ri, ii, ai, bi, oi, ce, j, su, fi, hlt;
    logic [2:0] step;
    logic [15:0] cw;

    int n_total;
    int n_bad;

    control_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .flag_c (flag_c),
        .flag_z (flag_z),
        .co     (co),
        .ro     (ro),
        .io     (io),
        .ao     (ao),
        .eo     (eo),
        .mi     (mi),
        .ri     (ri),
        .ii     (ii),
        .ai     (ai),
        .bi     (bi),
        .oi     (oi),
        .ce     (ce),
        .j      (j),
        .su     (su),
        .fi     (fi),
        .hlt    (hlt),
        .step   (step)
    );

    assign cw = {co, ro, io, ao, eo, mi, ri, ii, ai, bi, oi, ce, j, su, fi, hlt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Moves to 2ns after the next rising edge; inputs are driven there.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_state(input string tag, input logic [2:0] exp_step,
                                input logic [15:0] exp_cw);
        #1;
        chk({tag, ".step"}, {29'd0, step}, {29'd0, exp_step});
        chk({tag, ".cw"}, {16'd0, cw}, {16'd0, exp_cw});
    endtask

    // Runs one instruction starting at s0; opcode and flags are garbage during
    // fetch to show they are ignored there, and real from s2 onward.
    task automatic run_op(input string tag, input logic [3:0] op, input logic fc,
                          input logic fz, input int len, input logic [15:0] cw2,
                          input logic [15:0] cw3, input logic [15:0] cw4);
        opcode = ~op;
        flag_c = ~fc;
        flag_z = ~fz;
        expect_state({tag, ".s0"}, 3'd0, C_CO | C_MI);
        next_cycle();
        opcode = 4'($urandom_range(0, 15));
        expect_state({tag, ".s1"}, 3'd1, C_RO | C_II | C_CE);
        next_cycle();
        opcode = op;
        flag_c = fc;
        flag_z = fz;
        expect_state({tag, ".s2"}, 3'd2, cw2);
        if (len > 3) begin
            next_cycle();
            expect_state({tag, ".s3"}, 3'd3, cw3);
        end
        if (len > 4) begin
            next_cycle();
            expect_state({tag, ".s4"}, 3'd4, cw4);
        end
        next_cycle();
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        opcode  = 4'h2;
        flag_c  = 1'b0;
        flag_z  = 1'b0;

        next_cycle();
        expect_state("rst1", 3'd0, 16'h0000);
        next_cycle();
        expect_state("rst2", 3'd0, 16'h0000);
        rst = 1'b0;

        run_op("add",  4'h2, 1'b0, 1'b0, 5, C_IO | C_MI, C_RO | C_BI, C_EO | C_AI | C_FI);
        run_op("sub",  4'h3, 1'b0, 1'b0, 5, C_IO | C_MI, C_RO | C_BI,
               C_EO | C_AI | C_SU | C_FI);
        run_op("nop",  4'h0, 1'b0, 1'b0, 3, 16'h0000, 16'h0000, 16'h0000);
        run_op("lda",  4'h1, 1'b0, 1'b0, 4, C_IO | C_MI, C_RO | C_AI, 16'h0000);
        run_op("sta",  4'h4, 1'b0, 1'b0, 4, C_IO | C_MI, C_AO | C_RI, 16'h0000);
        run_op("ldi",  4'h5, 1'b0, 1'b0, 3, C_IO | C_AI, 16'h0000, 16'h0000);
        run_op("jmp",  4'h6, 1'b0, 1'b0, 3, C_IO | C_J, 16'h0000, 16'h0000);
        run_op("jc1",  4'h7, 1'b1, 1'b0, 3, C_IO | C_J, 16'h0000, 16'h0000);
        run_op("jc0",  4'h7, 1'b0, 1'b1, 3, 16'h0000, 16'h0000, 16'h0000);
        run_op("jz1",  4'h8, 1'b0, 1'b1, 3, C_IO | C_J, 16'h0000, 16'h0000);
        run_op("jz0",  4'h8, 1'b1, 1'b0, 3, 16'h0000, 16'h0000, 16'h0000);
        run_op("undB", 4'hB, 1'b1, 1'b1, 3, 16'h0000, 16'h0000, 16'h0000);
        run_op("out",  4'hE, 1'b0, 1'b0, 3, C_AO | C_OI, 16'h0000, 16'h0000);

        // Halt: s2 shows hlt, then frozen at step 2 regardless of inputs.
        opcode = 4'hF;
        expect_state("hlt.s0", 3'd0, C_CO | C_MI);
        next_cycle();
        expect_state("hlt.s1", 3'd1, C_RO | C_II | C_CE);
        next_cycle();
        expect_state("hlt.s2", 3'd2, C_HLT);
        for (int k = 0; k < 12; k++) begin
            next_cycle();
            opcode = 4'($urandom_range(0, 15));
            flag_c = 1'($urandom_range(0, 1));
            flag_z = 1'($urandom_range(0, 1));
            expect_state("hlt.hold", 3'd2, C_HLT);
        end
        rst = 1'b1;
        expect_state("hlt.rst_comb", 3'd2, 16'h0000);
        next_cycle();
        expect_state("hlt.rst_edge", 3'd0, 16'h0000);
        rst = 1'b0;

        // Abort LDA at s3.
        opcode = 4'h1;
        expect_state("mid.s0", 3'd0, C_CO | C_MI);
        next_cycle();
        expect_state("mid.s1", 3'd1, C_RO | C_II | C_CE);
        next_cycle();
        expect_state("mid.s2", 3'd2, C_IO | C_MI);
        next_cycle();
        expect_state("mid.s3", 3'd3, C_RO | C_AI);
        rst = 1'b1;
        expect_state("mid.rst_comb", 3'd3, 16'h0000);
        next_cycle();
        expect_state("mid.rst_edge", 3'd0, 16'h0000);
        rst = 1'b0;
        expect_state("mid.restart", 3'd0, C_CO | C_MI);

        // Randomized sweep: bus exclusivity, step range, outputs dark in reset.
        for (int k = 0; k < 1000; k++) begin
            next_cycle();
            opcode = 4'($urandom_range(0, 15));
            flag_c = 1'($urandom_range(0, 1));
            flag_z = 1'($urandom_range(0, 1));
            rst    = ($urandom_range(0, 15) == 0);
            #1;
            chk("rand.bus_onehot", {31'd0, ((32'(co) + 32'(ro) + 32'(io) + 32'(ao) + 32'(eo)) <= 32'd1)},
                32'd1);
            chk("rand.step_range", {31'd0, (step <= 3'd4)}, 32'd1);
            if (rst) begin
                chk("rand.rst_dark", {16'd0, cw}, 32'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microcode control sequencer for the 8-bit CPU. It steps a T-state counter through fetch and execute micro-steps and decodes the instruction-register opcode and ALU flags into the control word. The control word holds the load strobes for every register and the per-source bus output enables. Each output enable is the gating bit applied to its source's 8-bit value before that value reaches the shared bus, so this block sits directly upstream of every bus-gating stage.

## Interface
- No parameters; microcode is fixed.
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- opcode  input  4  upper nibble of the instruction register; valid from step 2 onward
- flag_c  input  1  registered ALU carry flag
- flag_z  input  1  registered ALU zero flag
- co  output  1  program counter bus output enable
- ro  output  1  RAM bus output enable
- io  output  1  IR low-nibble bus output enable
- ao  output  1  A register bus output enable
- eo  output  1  ALU result bus output enable
- mi, ri, ii, ai, bi, oi  output  1 each  load strobes for MAR, RAM, IR, A, B and the output register
- ce  output  1  program counter increment
- j  output  1  program counter load (jump)
- su  output  1  ALU subtract select
- fi  output  1  flags register load
- hlt  output  1  halt indicator; gates the CPU clock externally
- step  output  3  current T-state, for debug

## Operation
- State: step counter, 3 bits, range 0..4. Halted flag, 1 bit.
- Outputs are combinational from step, opcode, flag_c and flag_z. All unlisted outputs are 0.
- Fetch, identical for every instruction:
  - s0: co, mi
  - s1: ro, ii, ce
- Execute (opcode: steps, last step marked *):
  - 0x0 NOP: s2 empty*
  - 0x1 LDA: s2 io,mi; s3 ro,ai*
  - 0x2 ADD: s2 io,mi; s3 ro,bi; s4 eo,ai,fi*
  - 0x3 SUB: s2 io,mi; s3 ro,bi; s4 eo,ai,su,fi*
  - 0x4 STA: s2 io,mi; s3 ao,ri*
  - 0x5 LDI: s2 io,ai*
  - 0x6 JMP: s2 io,j*
  - 0x7 JC: s2 io,j only if flag_c=1, else empty*
  - 0x8 JZ: s2 io,j only if flag_z=1, else empty*
  - 0xE OUT: s2 ao,oi*
  - 0xF HLT: s2 hlt*
  - 0x9–0xD: treated as NOP
- Transitions:
  - On a step marked *, the next step is 0.
  - Otherwise the next step is step+1.
  - The counter never reaches 5.
- HLT:
  - At the edge ending s2, set halted=1 and freeze the step at 2.
  - While halted, hlt=1 and every other output is 0.
  - Only rst clears halted.
- Bus invariant: at most one of co, ro, io, ao, eo is 1 in any cycle, including while in reset.
- Flags are sampled combinationally only during s2 of JC/JZ. Flag changes at other steps have no effect.

## Timing
- Reset: rst is sampled at the rising edge. The next cycle has step=0 and halted=0.
- While rst=1, all control outputs are forced to 0 (including hlt), regardless of state.
- After rst deasserts, the first cycle is s0 (co=mi=1).
- Instruction length, counted from s0 with no wait states:
  - 3 cycles: NOP, LDI, JMP, JC, JZ, OUT and undefined opcodes
  - 4 cycles: LDA, STA
  - 5 cycles: ADD, SUB
- Control word latency: outputs reflect the new step within the same cycle in which the step register updates. Downstream registers capture on the next rising edge.
- rst asserted mid-instruction aborts it. The next cycle is s0 and no partial strobes persist.
- An opcode change during s0/s1 is ignored. The opcode is consumed only at s2..s4 and must be held stable through the last step.

## Test plan
- Reset: hold rst for 2 cycles with opcode=0x2 -> all outputs 0, step=0. Release -> cycle 1: co=mi=1. Cycle 2: ro=ii=ce=1.
- ADD sequence: opcode=0x2 -> step 0,1,2,3,4,0. s2: io,mi. s3: ro,bi. s4: eo,ai,fi with su=0. SUB 0x3 is identical except su=1 at s4.
- Conditional jumps:
  - JC with flag_c=1 -> s2 asserts io,j.
  - JC with flag_c=0 -> s2 outputs all 0.
  - Both cases: next step is 0.
  - Repeat for JZ with flag_z.
- HLT: opcode=0xF -> s2: hlt=1. Then step stays 2 and hlt stays 1 for 10+ cycles with all other outputs 0. A rst pulse -> step=0, hlt=0.
- Mid-instruction reset: assert rst during s3 of LDA -> next cycle step=0 and outputs 0 while rst is high.
- Bus invariant: random opcodes and flags over 1000 cycles with random rst -> sum of co,ro,io,ao,eo ≤1 every cycle, and step never exceeds 4.
